// File: rtl/wb_stage.sv
// MEM/WB register and writeback datapath: load alignment, result select, regfile write.
// Define WB_INSTRET_EN to build the 64-bit retired-instruction counter.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_valid,
  input  logic            mem_reg_we,
  input  logic [4:0]      mem_rd_addr,
  input  logic [1:0]      mem_wb_sel,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_addr_lo,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic            stall,
  input  logic            flush,
  output logic            write_en,
  output logic [4:0]      write_addr,
  output logic [XLEN-1:0] write_value,
  output logic            wb_valid,
  output logic [63:0]     instret
);

  logic            valid_q, valid_d;
  logic            committed_q, committed_d;
  logic            reg_we_q, reg_we_d;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      sel_q, sel_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] ld_q, ld_d;

  logic            retire;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;

  assign retire     = valid_q & ~committed_q;
  assign write_en   = retire & reg_we_q & (rd_q != 5'd0);
  assign write_addr = rd_q;
  assign wb_valid   = valid_q;

  always_comb begin
    valid_d     = valid_q;
    committed_d = committed_q;
    reg_we_d    = reg_we_q;
    rd_d        = rd_q;
    sel_d       = sel_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    alu_d       = alu_q;
    pc4_d       = pc4_q;
    ld_d        = ld_q;
    if (flush) begin
      valid_d     = 1'b0;
      committed_d = 1'b0;
    end else if (stall) begin
      // a held instruction has written/retired once it spent a cycle here
      committed_d = committed_q | write_en | retire;
    end else begin
      valid_d     = mem_valid;
      committed_d = 1'b0;
      reg_we_d    = mem_reg_we;
      rd_d        = mem_rd_addr;
      sel_d       = mem_wb_sel;
      f3_d        = mem_funct3;
      lo_d        = mem_addr_lo;
      alu_d       = mem_alu_result;
      pc4_d       = mem_pc_plus4;
      ld_d        = mem_load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      committed_q <= 1'b0;
      reg_we_q    <= 1'b0;
      rd_q        <= 5'd0;
      sel_q       <= 2'd0;
      f3_q        <= 3'd0;
      lo_q        <= 2'd0;
      alu_q       <= '0;
      pc4_q       <= '0;
      ld_q        <= '0;
    end else begin
      valid_q     <= valid_d;
      committed_q <= committed_d;
      reg_we_q    <= reg_we_d;
      rd_q        <= rd_d;
      sel_q       <= sel_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      alu_q       <= alu_d;
      pc4_q       <= pc4_d;
      ld_q        <= ld_d;
    end
  end

  assign ld_byte = ld_q[8*lo_q +: 8];
  assign ld_half = ld_q[16*lo_q[1] +: 16];

  always_comb begin
    ld_val = '0;
    case (f3_q)
      3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
      3'b010:  ld_val = ld_q;
      default: ld_val = '0;
    endcase
  end

  always_comb begin
    write_value = '0;
    case (sel_q)
      2'b00:   write_value = alu_q;
      2'b01:   write_value = ld_val;
      2'b10:   write_value = pc4_q;
      default: write_value = '0;
    endcase
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb instret_d = instret_q + {63'd0, retire};

  always_ff @(posedge clk) begin
    if (reset) instret_q <= 64'd0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed test-plan cases then randomized traffic.
// Reference model tracks instructions entering WB, expected writes and retire count.
module tb_wb_stage;

`ifdef WB_INSTRET_EN
  localparam bit IR_EN = 1'b1;
`else
  localparam bit IR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_reg_we;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu_result, mem_pc_plus4, mem_load_data;
  logic        stall, flush;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_value;
  logic        wb_valid;
  logic [63:0] instret;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_reg_we(mem_reg_we),
    .mem_rd_addr(mem_rd_addr), .mem_wb_sel(mem_wb_sel),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .mem_load_data(mem_load_data),
    .stall(stall), .flush(flush),
    .write_en(write_en), .write_addr(write_addr),
    .write_value(write_value), .wb_valid(wb_valid),
    .instret(instret)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct { logic [4:0] addr; logic [31:0] val; } wr_t;
  wr_t         exp_q[$];
  bit          started = 0;
  bit          m_valid = 0;
  bit          m_pend = 0;
  bit          exp_w = 0;
  logic [63:0] m_cnt = 0;
  bit          pre_tgl = 0;
  bit          pre_seen = 0;

  function automatic logic [31:0] load_val(input logic [2:0] f3,
                                           input logic [1:0] lo,
                                           input logic [31:0] w);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    int boff, hoff;
    boff = 8 * int'(lo);
    hoff = (lo >= 2) ? 16 : 0;
    sb = 8'(w >> boff);
    sh = 16'(w >> hoff);
    case (f3)
      3'd0: return 32'(sb);
      3'd4: return (w >> boff) & 32'hFF;
      3'd1: return 32'(sh);
      3'd5: return (w >> hoff) & 32'hFFFF;
      3'd2: return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] result(input logic [1:0] sel,
                                         input logic [2:0] f3,
                                         input logic [1:0] lo,
                                         input logic [31:0] alu,
                                         input logic [31:0] pc4,
                                         input logic [31:0] ld);
    if (sel == 2'd0) return alu;
    if (sel == 2'd2) return pc4;
    if (sel == 2'd1) return load_val(f3, lo, ld);
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    exp_w = 0;
    if (pre_tgl != pre_seen) begin
      m_cnt = '1;
      pre_seen = pre_tgl;
    end
    if (reset) begin
      started = 1;
      m_valid = 0;
      m_pend = 0;
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 64'(m_pend);
      m_pend = 0;
      if (flush) m_valid = 0;
      else if (!stall) begin
        m_valid = mem_valid;
        if (mem_valid) begin
          m_pend = 1;
          if (mem_reg_we && mem_rd_addr != 0) begin
            exp_w = 1;
            exp_q.push_back('{mem_rd_addr,
              result(mem_wb_sel, mem_funct3, mem_addr_lo,
                     mem_alu_result, mem_pc_plus4, mem_load_data)});
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge
  always @(negedge clk) begin
    if (started) begin
      wr_t e;
      checks++;
      if (write_en !== exp_w) begin
        errors++;
        $display("FAIL mon_write_en: got %b want %b t=%0t", write_en, exp_w, $time);
      end
      if (write_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_extra_write: got addr %0d val %h want none",
                   write_addr, write_value);
        end else begin
          e = exp_q.pop_front();
          if (write_addr !== e.addr || write_value !== e.val) begin
            errors++;
            $display("FAIL mon_write: got %0d/%h want %0d/%h t=%0t",
                     write_addr, write_value, e.addr, e.val, $time);
          end
        end
      end
      checks++;
      if (wb_valid !== m_valid) begin
        errors++;
        $display("FAIL mon_wb_valid: got %b want %b t=%0t", wb_valid, m_valid, $time);
      end
      checks++;
      if (instret !== (IR_EN ? m_cnt : 64'd0)) begin
        errors++;
        $display("FAIL mon_instret: got %h want %h t=%0t", instret,
                 IR_EN ? m_cnt : 64'd0, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic cyc(input logic v, input logic we, input logic [4:0] rd,
                     input logic [1:0] sel, input logic [2:0] f3,
                     input logic [1:0] lo, input logic [31:0] alu,
                     input logic [31:0] pc4, input logic [31:0] ld,
                     input logic st, input logic fl, input logic rs);
    @(negedge clk);
    mem_valid = v; mem_reg_we = we; mem_rd_addr = rd;
    mem_wb_sel = sel; mem_funct3 = f3; mem_addr_lo = lo;
    mem_alu_result = alu; mem_pc_plus4 = pc4; mem_load_data = ld;
    stall = st; flush = fl; reset = rs;
  endtask

  task automatic idle(input logic st = 0, input logic fl = 0, input logic rs = 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, st, fl, rs);
  endtask

  logic [31:0] lw_word = 32'h80F0_7F81;
  logic [2:0]  ld_f3[5]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [1:0]  ld_lo[5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] ld_exp[5] = '{32'hFFFF_FF81, 32'h0000_007F, 32'hFFFF_80F0,
                             32'h0000_80F0, 32'h80F0_7F81};
  logic [63:0] base;

  initial begin
    reset = 1; stall = 0; flush = 0;
    mem_valid = 0; mem_reg_we = 0; mem_rd_addr = 0; mem_wb_sel = 0;
    mem_funct3 = 0; mem_addr_lo = 0; mem_alu_result = 0;
    mem_pc_plus4 = 0; mem_load_data = 0;
    idle(0, 0, 1);
    idle(0, 0, 1);
    idle();
    chk("rst_write_en", 64'(write_en), 0);
    chk("rst_write_addr", 64'(write_addr), 0);
    chk("rst_write_value", 64'(write_value), 0);
    chk("rst_wb_valid", 64'(wb_valid), 0);
    chk("rst_instret", instret, 0);

    cyc(1, 1, 5, 0, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0);
    idle();
    chk("alu_write_en", 64'(write_en), 1);
    chk("alu_write_addr", 64'(write_addr), 5);
    chk("alu_write_value", 64'(write_value), 64'h1234_5678);
    idle();
    chk("alu_instret", instret, IR_EN ? 64'd1 : 64'd0);

    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 3, 1, ld_f3[i], ld_lo[i], 0, 0, lw_word, 0, 0, 0);
      idle();
      chk($sformatf("load_%0d", i), 64'(write_value), 64'(ld_exp[i]));
    end

    base = instret;
    cyc(1, 1, 0, 0, 0, 0, 32'hDEAD, 0, 0, 0, 0, 0);
    idle();
    chk("x0_write_en", 64'(write_en), 0);
    idle();
    chk("x0_instret", instret, base + 64'(IR_EN));

    base = instret;
    cyc(1, 1, 7, 2, 0, 0, 0, 32'h104, 0, 0, 0, 0);
    idle(1);
    chk("stall_first_en", 64'(write_en), 1);
    chk("stall_first_val", 64'(write_value), 64'h104);
    idle(1);
    chk("stall_2_en", 64'(write_en), 0);
    chk("stall_2_valid", 64'(wb_valid), 1);
    idle(1);
    chk("stall_3_en", 64'(write_en), 0);
    idle();
    chk("stall_end_valid", 64'(wb_valid), 1);
    chk("stall_instret", instret, base + 64'(IR_EN));

    cyc(1, 1, 9, 0, 0, 0, 32'hAA, 0, 0, 0, 0, 0);
    idle(1, 1);
    chk("flush_pre_en", 64'(write_en), 1);
    idle();
    chk("flush_valid", 64'(wb_valid), 0);
    chk("flush_en", 64'(write_en), 0);
    cyc(1, 1, 10, 0, 0, 0, 32'h55, 0, 0, 0, 0, 0);
    idle();
    chk("post_flush_addr", 64'(write_addr), 10);
    chk("post_flush_val", 64'(write_value), 64'h55);

`ifdef WB_INSTRET_EN
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    #1;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    pre_tgl = ~pre_tgl;
    #1;
    release dut.instret_q;
    idle();
    chk("instret_wrap", instret, 64'd0);
`endif

    cyc(1, 1, 4, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0);
    idle(1);
    idle(1, 0, 1);
    idle();
    chk("mid_rst_en", 64'(write_en), 0);
    chk("mid_rst_addr", 64'(write_addr), 0);
    chk("mid_rst_val", 64'(write_value), 0);
    chk("mid_rst_valid", 64'(wb_valid), 0);
    chk("mid_rst_instret", instret, 0);

    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 4) != 0, $urandom % 2, 5'($urandom),
          2'($urandom), 3'($urandom), 2'($urandom),
          $urandom, $urandom, $urandom,
          ($urandom % 4) == 0, ($urandom % 10) == 0,
          ($urandom % 150) == 0);
    end
    idle();
    idle();
    idle();
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
